uart_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one UART TX path (TX FIFO plus transmitter) among `NUM_REQ` byte-stream requesters, such as the register interface, DMA and the RX echo path. It grants one requester at a time and holds the grant until that requester's last byte or a burst limit, so packets never interleave. It drives the TX FIFO write port directly and never writes while the FIFO reports full.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : requester byte streams plus TX FIFO write port
// Revision: 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_wr_data;
  logic                          tx_wr_en;
  logic                          tx_full;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_wr_data, tx_wr_en
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_wr_data, tx_wr_en
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : packet-granular round-robin arbiter feeding the UART TX FIFO
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                       uart_clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.slave           bus,
  input  logic                       pause,
  input  logic                       flush,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       burst_cut
);

  localparam int c_GW = $clog2(NUM_REQ);
  localparam int c_CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] c_S_IDLE  = 1'b0;
  localparam logic [0:0] c_S_GRANT = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_next_state;
  logic [c_GW-1:0]       r_last_ptr;
  logic [c_GW-1:0]       r_grant_id;
  logic [c_CW-1:0]       r_beat_cnt;
  logic                  r_burst_cut;

  logic [c_GW-1:0]       w_pick;
  logic                  w_start;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_cnt_hit;
  logic                  w_release;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_wr_en;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Descending scan so the smallest offset from last_ptr+1 wins.
  always_comb begin
    w_pick = r_last_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(r_last_ptr) + k) % NUM_REQ]) begin
        w_pick = c_GW'((int'(r_last_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_start    = (r_state == c_S_IDLE) && !flush && !pause && (|bus.req_valid);
  assign w_last     = bus.req_last[r_grant_id];
  assign w_acc      = (r_state == c_S_GRANT) && bus.req_valid[r_grant_id] && !bus.tx_full;
  assign w_cnt_hit  = (r_beat_cnt == c_CW'(MAX_BURST - 1));
  assign w_release  = w_acc && (w_last || w_cnt_hit);
  assign w_sel_data = bus.req_data[int'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE:  if (w_start) w_next_state = c_S_GRANT;
      c_S_GRANT: if (flush || w_release) w_next_state = c_S_IDLE;
      default:   w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = '0;
    w_wr_en = 1'b0;
    w_busy  = (r_state == c_S_GRANT);
    if (r_state == c_S_GRANT) begin
      w_ready[r_grant_id] = !bus.tx_full;
      w_wr_en             = w_acc;
    end
  end

  // A flush that coincides with the count limit is an abort, not a burst cut.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ptr  <= c_GW'(NUM_REQ - 1);
      r_grant_id  <= '0;
      r_beat_cnt  <= '0;
      r_burst_cut <= 1'b0;
    end else begin
      r_burst_cut <= w_acc && w_cnt_hit && !w_last && !flush;
      if (w_start) begin
        r_grant_id <= w_pick;
        r_beat_cnt <= '0;
      end else if (flush || w_release) begin
        r_beat_cnt <= '0;
      end else if (w_acc) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if ((r_state == c_S_GRANT) && (flush || w_release)) begin
        r_last_ptr <= r_grant_id;
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.tx_wr_en   = w_wr_en;
  assign bus.tx_wr_data = w_sel_data;
  assign grant_id       = r_grant_id;
  assign busy           = w_busy;
  assign burst_cut      = r_burst_cut;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : randomized scoreboard bench for uart_tx_arbiter
// Revision: 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic       uart_clk;
  logic       rst_n;
  logic       pause;
  logic       flush;
  logic [1:0] grant_id;
  logic       busy;
  logic       burst_cut;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) ifc ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .uart_clk (uart_clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .pause    (pause),
    .flush    (flush),
    .grant_id (grant_id),
    .busy     (busy),
    .burst_cut(burst_cut)
  );

  initial begin
    uart_clk = 1'b0;
    forever #5 uart_clk = ~uart_clk;
  end

  int checks = 0;
  int errors = 0;

  // Per-requester byte sources {last, data} and expected TX byte streams.
  logic [8:0] src_q[NUM_REQ][$];
  logic [7:0] exp_q[NUM_REQ][$];

  int vprob  = 100;
  int fprob  = 0;
  int flprob = 0;
  bit pause_knob = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input int base);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = (base < 0) ? 8'($urandom) : 8'(base + b);
      src_q[r].push_back({(b == len - 1), d});
      exp_q[r].push_back(d);
    end
  endtask

  // Drive at the falling edge; just before the rising edge, retire accepted bytes.
  task automatic drive_cycle();
    logic [NUM_REQ-1:0]            v;
    logic [NUM_REQ-1:0]            l;
    logic [NUM_REQ*DATA_WIDTH-1:0] d;
    @(negedge uart_clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0 && $urandom_range(99) < vprob) begin
        v[i] = 1'b1;
        l[i] = src_q[i][0][8];
        d[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0][7:0];
      end else begin
        v[i] = 1'b0;
        l[i] = 1'($urandom);
        d[i*DATA_WIDTH +: DATA_WIDTH] = 8'($urandom);
      end
    end
    ifc.req_valid = v;
    ifc.req_last  = l;
    ifc.req_data  = d;
    ifc.tx_full   = ($urandom_range(99) < fprob);
    flush         = ($urandom_range(99) < flprob);
    pause         = pause_knob;
    #4;
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (v[i] && ifc.req_ready[i]) void'(src_q[i].pop_front());
      end
    end
  endtask

  task automatic drain(input int bound);
    int n;
    vprob = 100; fprob = 0; flprob = 0; pause_knob = 1'b0;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0 && n < bound) begin
      drive_cycle();
      n++;
    end
    chk(n < bound, "drain_timeout", n, bound);
    repeat (3) drive_cycle();
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return 0;
  endfunction

  // Monitor / reference model: a grant is a run of beats owned by one
  // requester; it is picked round-robin from the requests seen one cycle
  // earlier and ends on last, after MAX_BURST beats, or on flush.
  initial begin : monitor
    logic [NUM_REQ-1:0] p_valid;
    logic [NUM_REQ-1:0] e_ready;
    bit p_busy, p_flush, p_pause, p_rel, p_cut, e_busy, e_wen, cur_last;
    int m_ptr, m_gid, m_beats;
    logic [7:0] e_data;
    p_valid = '0; p_busy = 0; p_flush = 0; p_pause = 0; p_rel = 0; p_cut = 0;
    m_ptr = NUM_REQ - 1; m_gid = 0; m_beats = 0;
    forever begin
      @(negedge uart_clk);
      #3;
      if (!rst_n) begin
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(ifc.tx_wr_en == 1'b0, "rst_wr_en", ifc.tx_wr_en, 0);
        chk(ifc.req_ready == '0, "rst_ready", ifc.req_ready, 0);
        chk(grant_id == 2'd0, "rst_grant_id", grant_id, 0);
        chk(burst_cut == 1'b0, "rst_burst_cut", burst_cut, 0);
        p_valid = '0; p_busy = 0; p_flush = 0; p_pause = 0; p_rel = 0; p_cut = 0;
        m_ptr = NUM_REQ - 1; m_gid = 0; m_beats = 0;
      end else begin
        if (p_busy) e_busy = !(p_flush || p_rel);
        else        e_busy = !p_flush && !p_pause && (p_valid != '0);
        if (e_busy && !p_busy) begin
          m_gid   = pick(p_valid, m_ptr);
          m_beats = 0;
        end
        chk(busy == e_busy, "busy", busy, e_busy);
        chk(burst_cut == p_cut, "burst_cut", burst_cut, p_cut);
        chk(grant_id == 2'(m_gid), "grant_id", grant_id, m_gid);
        e_ready = '0;
        if (e_busy && !ifc.tx_full) e_ready[m_gid] = 1'b1;
        chk(ifc.req_ready == e_ready, "req_ready", ifc.req_ready, e_ready);
        e_wen = e_busy && ifc.req_valid[m_gid] && !ifc.tx_full;
        chk(ifc.tx_wr_en == e_wen, "tx_wr_en", ifc.tx_wr_en, e_wen);
        if (e_wen) begin
          if (exp_q[m_gid].size() == 0) begin
            chk(1'b0, "tx_underflow", m_gid, 0);
          end else begin
            e_data = exp_q[m_gid].pop_front();
            chk(ifc.tx_wr_data == e_data, "tx_wr_data", ifc.tx_wr_data, e_data);
          end
        end
        cur_last = ifc.req_last[m_gid];
        p_rel    = e_wen && (cur_last || m_beats == MAX_BURST - 1);
        p_cut    = p_rel && !cur_last && !flush;
        if (e_busy && (flush || p_rel)) m_ptr = m_gid;
        if (e_wen) m_beats++;
        p_busy  = e_busy;
        p_valid = ifc.req_valid;
        p_flush = flush;
        p_pause = pause;
      end
    end
  end

  initial begin : stimulus
    int n;
    rst_n = 1'b0; pause = 1'b0; flush = 1'b0;
    ifc.req_valid = '0; ifc.req_last = '0; ifc.req_data = '0; ifc.tx_full = 1'b0;
    repeat (3) drive_cycle();
    @(negedge uart_clk);
    rst_n = 1'b1;

    // Single packet from requester 1.
    push_pkt(1, 3, 'h41);
    drain(50);

    // Round robin with every requester holding a 2-byte packet.
    for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 2, 16 * i);
    push_pkt(0, 2, 'h80);
    drain(100);

    // FIFO backpressure on a 4-byte packet.
    push_pkt(0, 4, -1);
    fprob = 50;
    for (n = 0; n < 100 && src_q[0].size() != 0; n++) drive_cycle();
    drain(50);

    // Burst cut: 6-byte packet on requester 0 while requester 1 waits.
    push_pkt(0, 6, 'hA0);
    push_pkt(1, 2, 'hB0);
    drain(100);

    // Flush after two bytes of a 5-byte packet on requester 2.
    push_pkt(2, 5, 'hC0);
    for (n = 0; n < 50 && src_q[2].size() > 3; n++) drive_cycle();
    chk(src_q[2].size() == 3, "flush_setup", src_q[2].size(), 3);
    push_pkt(0, 2, 'hD0);
    flprob = 100;
    drive_cycle();
    flprob = 0;
    drain(100);

    // Pause holds off new grants.
    pause_knob = 1'b1;
    push_pkt(0, 2, -1);
    push_pkt(1, 2, -1);
    repeat (8) drive_cycle();
    drain(100);

    // Asynchronous reset mid-grant.
    push_pkt(2, 6, -1);
    for (n = 0; n < 50 && !busy; n++) drive_cycle();
    chk(busy == 1'b1, "reset_setup", busy, 1);
    drive_cycle();
    @(negedge uart_clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge uart_clk);
    rst_n = 1'b1;
    drain(100);

    // Randomized traffic.
    vprob = 80; fprob = 20; flprob = 3;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99) < 15) begin
        n = $urandom_range(NUM_REQ - 1);
        if (src_q[n].size() < 12) push_pkt(n, $urandom_range(7, 1), -1);
      end
      pause_knob = ($urandom_range(99) < 10);
      drive_cycle();
    end
    drain(500);

    for (int i = 0; i < NUM_REQ; i++) begin
      chk(exp_q[i].size() == 0, "leftover_bytes", exp_q[i].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
